// File: rtl/bpu_gshare_pkg.sv
// Shared constants, types and helpers for the gshare branch predict unit.
// Contents: RV opcodes for control transfers, link-register numbers,
// 2-bit counter encodings, predecode result struct and decoder.
package bpu_gshare_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [4:0] REG_LINK_RA = 5'd1;
  localparam logic [4:0] REG_LINK_T0 = 5'd5;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic        op_bxx;
    logic        op_jal;
    logic        op_jalr;
    logic [31:0] jump_imm;
    logic [4:0]  rs1;
    logic [4:0]  rd;
  } predec_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_LINK_RA) || (r == REG_LINK_T0);
  endfunction

  function automatic predec_t predecode(input logic [31:0] inst);
    predec_t p;
    p.op_bxx   = (inst[6:0] == OPC_BRANCH);
    p.op_jal   = (inst[6:0] == OPC_JAL);
    p.op_jalr  = (inst[6:0] == OPC_JALR) && (inst[14:12] == 3'b000);
    p.rs1      = inst[19:15];
    p.rd       = inst[11:7];
    p.jump_imm = '0;
    if (p.op_bxx)
      p.jump_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (p.op_jal)
      p.jump_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    else if (p.op_jalr)
      p.jump_imm = {{20{inst[31]}}, inst[31:20]};
    return p;
  endfunction

  // Saturating 2-bit counter step.
  function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken && (c != CTR_ST))
      n = ctr_t'(c + 2'd1);
    else if (!taken && (c != CTR_SNT))
      n = ctr_t'(c - 2'd1);
    return n;
  endfunction

endpackage

// File: rtl/bpu_gshare_ras.sv
// Circular return address stack with push, pop, replace and checkpoint restore.
// Latency: top/empty/checkpoint are combinational from state; updates land next clk edge.
// Backpressure: none; push on full overwrites the oldest entry, pop on empty is ignored.
// Ports: push/pop (both = replace top), push_addr, restore/restore_ck ({ptr,count}),
//        top_addr, empty, ck.
module bpu_gshare_ras
  import bpu_gshare_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4,
  parameter int RAS_PW    = $clog2(RAS_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_W-1:0]     push_addr,
  input  logic                  restore,
  input  logic [2*RAS_PW:0]     restore_ck,
  output logic [ADDR_W-1:0]     top_addr,
  output logic                  empty,
  output logic [2*RAS_PW:0]     ck
);

  localparam logic [RAS_PW:0]   CNT_FULL = (RAS_PW+1)'(RAS_DEPTH);
  localparam logic [RAS_PW:0]   CNT_ONE  = (RAS_PW+1)'(1);
  localparam logic [RAS_PW-1:0] PTR_ONE  = RAS_PW'(1);

  logic [ADDR_W-1:0] entries [RAS_DEPTH];
  logic [RAS_PW-1:0] ptr;      // next free slot; top lives at ptr-1
  logic [RAS_PW:0]   count;
  logic [RAS_PW-1:0] top_idx;

  assign top_idx  = ptr - PTR_ONE;
  assign top_addr = entries[top_idx];
  assign empty    = (count == '0);
  assign ck       = {ptr, count};

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
    end else if (restore) begin
      // Only ptr/count are repaired; entry contents keep whatever was written.
      ptr   <= restore_ck[2*RAS_PW -: RAS_PW];
      count <= restore_ck[RAS_PW:0];
    end else if (push && pop && !empty) begin
      entries[top_idx] <= push_addr;
    end else if (push) begin
      entries[ptr] <= push_addr;
      ptr          <= ptr + PTR_ONE;
      if (count != CNT_FULL) count <= count + CNT_ONE;
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/bpu_gshare.sv
// Gshare direction + RAS/JAL target predictor for the fetch stage, speculatively updated.
// Latency: prediction is combinational (zero cycles); state changes at next clk edge.
// Backpressure: none; the predict and update ports are accepted every cycle.
// Ports: pred_* in (fetch PC/inst) -> pred_taken/pred_target/jalr_need_rs1 plus
//        pred_ghr/pred_ras_ck checkpoints; upd_* in (EXU resolution, PHT train, repair).
module bpu_gshare
  import bpu_gshare_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int PHT_IDX_W = 10,
  parameter int GHR_W     = 8,
  parameter int RAS_DEPTH = 4,
  parameter int RAS_PW    = $clog2(RAS_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [ADDR_W-1:0]        pred_pc,
  input  logic [31:0]              pred_inst,
  output logic                     pred_taken,
  output logic [ADDR_W-1:0]        pred_target,
  output logic                     jalr_need_rs1,
  output logic [GHR_W-1:0]         pred_ghr,
  output logic [RAS_PW+RAS_PW:0]   pred_ras_ck,
  input  logic                     upd_valid,
  input  logic [ADDR_W-1:0]        upd_pc,
  input  logic                     upd_is_bxx,
  input  logic                     upd_taken,
  input  logic                     upd_mispredict,
  input  logic [GHR_W-1:0]         upd_ghr,
  input  logic [RAS_PW+RAS_PW:0]   upd_ras_ck
);

  localparam int PHT_SIZE = 1 << PHT_IDX_W;

  ctr_t                 pht [PHT_SIZE];
  logic [GHR_W-1:0]     ghr;
  logic [PHT_IDX_W-1:0] pred_idx;
  logic [PHT_IDX_W-1:0] upd_idx;
  logic                 pht_dir;

  predec_t              pd;
  logic                 rd_link;
  logic                 rs1_link;
  logic [ADDR_W-1:0]    imm_ext;
  logic [ADDR_W-1:0]    rel_target;
  logic                 ras_push;
  logic                 ras_pop;
  logic                 ras_empty;
  logic [ADDR_W-1:0]    ras_top;
  logic                 repair;

  logic                 unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[ADDR_W-1:PHT_IDX_W+2], upd_pc[1:0]};

  assign pd         = predecode(pred_inst);
  assign rd_link    = is_link(pd.rd);
  assign rs1_link   = is_link(pd.rs1);
  assign imm_ext    = ADDR_W'($signed(pd.jump_imm));
  assign rel_target = pred_pc + imm_ext;

  assign pred_idx = pred_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  assign upd_idx  = upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr);
  assign pht_dir  = pht[pred_idx][1];

  // Call pushes, return pops; both together with distinct link regs replaces the top.
  assign ras_push = pred_valid && (pd.op_jal || pd.op_jalr) && rd_link;
  assign ras_pop  = pred_valid && pd.op_jalr && rs1_link && (!rd_link || (pd.rd != pd.rs1));
  assign repair   = upd_valid && upd_mispredict;

  assign pred_ghr = ghr;

  always_comb begin
    pred_taken    = 1'b0;
    pred_target   = '0;
    jalr_need_rs1 = 1'b0;
    if (pred_valid) begin
      if (pd.op_bxx) begin
        pred_taken  = pht_dir;
        pred_target = pht_dir ? rel_target : '0;
      end else if (pd.op_jal) begin
        pred_taken  = 1'b1;
        pred_target = rel_target;
      end else if (pd.op_jalr) begin
        if (pd.rs1 == 5'd0) begin
          pred_taken  = 1'b1;
          pred_target = imm_ext;
        end else if (rs1_link && !ras_empty) begin
          pred_taken  = 1'b1;
          pred_target = ras_top;
        end else begin
          jalr_need_rs1 = 1'b1;
        end
      end
    end
  end

  // A mispredict repair wins over this cycle's speculative shift.
  always_ff @(posedge clk) begin
    if (rst)
      ghr <= '0;
    else if (repair)
      ghr <= upd_is_bxx ? GHR_W'({upd_ghr, upd_taken}) : upd_ghr;
    else if (pred_valid && pd.op_bxx)
      ghr <= GHR_W'({ghr, pht_dir});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_SIZE; i++) pht[i] <= CTR_WNT;
    end else if (upd_valid && upd_is_bxx) begin
      pht[upd_idx] <= ctr_update(pht[upd_idx], upd_taken);
    end
  end

  bpu_gshare_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RAS_PW    (RAS_PW)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push       (ras_push),
    .pop        (ras_pop),
    .push_addr  (pred_pc + ADDR_W'(4)),
    .restore    (repair),
    .restore_ck (upd_ras_ck),
    .top_addr   (ras_top),
    .empty      (ras_empty),
    .ck         (pred_ras_ck)
  );

endmodule

// File: tb/tb_bpu_gshare.sv
// Directed bench for bpu_gshare with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled after settling.
module tb_bpu_gshare;

  localparam int ADDR_W    = 32;
  localparam int PHT_IDX_W = 10;
  localparam int GHR_W     = 8;
  localparam int RAS_DEPTH = 4;
  localparam int RAS_PW    = 2;

  // beq x0,x0,+0x20 / jal ra,+0x100 / jalr x0,0(ra) / jalr t0,0(ra)
  // jalr x0,0x40(x0) / jalr x0,0(a0)
  localparam logic [31:0] I_BEQ      = 32'h02000063;
  localparam logic [31:0] I_JAL_RA   = 32'h100000EF;
  localparam logic [31:0] I_RET      = 32'h00008067;
  localparam logic [31:0] I_SWAP     = 32'h000082E7;
  localparam logic [31:0] I_JALR_ABS = 32'h04000067;
  localparam logic [31:0] I_JALR_A0  = 32'h00050067;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   pred_valid;
  logic [ADDR_W-1:0]      pred_pc;
  logic [31:0]            pred_inst;
  logic                   pred_taken;
  logic [ADDR_W-1:0]      pred_target;
  logic                   jalr_need_rs1;
  logic [GHR_W-1:0]       pred_ghr;
  logic [2*RAS_PW:0]      pred_ras_ck;
  logic                   upd_valid;
  logic [ADDR_W-1:0]      upd_pc;
  logic                   upd_is_bxx;
  logic                   upd_taken;
  logic                   upd_mispredict;
  logic [GHR_W-1:0]       upd_ghr;
  logic [2*RAS_PW:0]      upd_ras_ck;

  int n_cmp = 0;
  int n_bad = 0;

  bpu_gshare #(
    .ADDR_W(ADDR_W), .PHT_IDX_W(PHT_IDX_W), .GHR_W(GHR_W),
    .RAS_DEPTH(RAS_DEPTH), .RAS_PW(RAS_PW)
  ) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_inst(pred_inst),
    .pred_taken(pred_taken), .pred_target(pred_target), .jalr_need_rs1(jalr_need_rs1),
    .pred_ghr(pred_ghr), .pred_ras_ck(pred_ras_ck),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_bxx(upd_is_bxx),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .upd_ghr(upd_ghr), .upd_ras_ck(upd_ras_ck)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid     = 1'b0;
    pred_pc        = '0;
    pred_inst      = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_is_bxx     = 1'b0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
    upd_ghr        = '0;
    upd_ras_ck     = '0;
  endtask

  task automatic predict(input logic [31:0] pc, input logic [31:0] inst);
    pred_valid = 1'b1;
    pred_pc    = pc;
    pred_inst  = inst;
  endtask

  task automatic update(input logic [31:0] pc, input logic bxx, input logic tk,
                        input logic misp, input logic [7:0] g, input logic [4:0] ck);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_is_bxx     = bxx;
    upd_taken      = tk;
    upd_mispredict = misp;
    upd_ghr        = g;
    upd_ras_ck     = ck;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Train the counter at PC 0x100 / GHR 0 (index 0x40).
  task automatic train(input logic tk);
    update(32'h100, 1'b1, tk, 1'b0, 8'h00, 5'h00);
    tick();
    idle();
  endtask

  // Look at the direction for BEQ at 0x100 without letting it shift the GHR.
  task automatic probe(input string tag, input logic exp_tk);
    predict(32'h100, I_BEQ);
    #1;
    chk(tag, 64'(pred_taken), 64'(exp_tk));
    pred_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_taken",  64'(pred_taken),    64'd0);
    chk("rst_target", 64'(pred_target),   64'd0);
    chk("rst_need",   64'(jalr_need_rs1), 64'd0);
    chk("rst_ghr",    64'(pred_ghr),      64'd0);
    chk("rst_ck",     64'(pred_ras_ck),   64'd0);

    // Cold branch: counter 01 -> not taken, GHR shifts in a 0.
    predict(32'h100, I_BEQ);
    #1;
    chk("cold_beq_taken",  64'(pred_taken),  64'd0);
    chk("cold_beq_target", 64'(pred_target), 64'd0);
    tick();
    idle();
    #1;
    chk("cold_beq_ghr", 64'(pred_ghr), 64'd0);

    // Two taken updates: 01 -> 10 -> 11.
    update(32'h100, 1'b1, 1'b1, 1'b0, 8'h00, 5'h00);
    tick();
    tick();
    idle();
    predict(32'h100, I_BEQ);
    #1;
    chk("trained_taken",  64'(pred_taken),  64'd1);
    chk("trained_target", 64'(pred_target), 64'h120);
    pred_valid = 1'b0;
    train(1'b1);                       // stays 11
    probe("sat_hi_taken", 1'b1);
    train(1'b0);                       // 10
    probe("after_1nt", 1'b1);
    train(1'b0);                       // 01
    probe("after_2nt", 1'b0);
    train(1'b0);                       // 00
    train(1'b0);                       // stays 00
    probe("after_4nt", 1'b0);
    train(1'b1);                       // 01
    probe("sat_lo_then_t", 1'b0);
    train(1'b1);                       // 10
    probe("sat_lo_then_2t", 1'b1);
    chk("ghr_untouched", 64'(pred_ghr), 64'd0);

    // Validity gate on a JAL.
    predict(32'h200, I_JAL_RA);
    pred_valid = 1'b0;
    #1;
    chk("gate_taken",  64'(pred_taken),  64'd0);
    chk("gate_target", 64'(pred_target), 64'd0);

    // Call / replace / return / empty return.
    predict(32'h200, I_JAL_RA);
    #1;
    chk("jal_taken",  64'(pred_taken),  64'd1);
    chk("jal_target", 64'(pred_target), 64'h300);
    tick();
    idle();
    #1;
    chk("ck_after_call", 64'(pred_ras_ck), 64'h09);
    predict(32'h300, I_SWAP);
    #1;
    chk("swap_target", 64'(pred_target), 64'h204);
    tick();
    idle();
    #1;
    chk("ck_after_swap", 64'(pred_ras_ck), 64'h09);
    predict(32'h400, I_RET);
    #1;
    chk("ret_taken",  64'(pred_taken),    64'd1);
    chk("ret_target", 64'(pred_target),   64'h304);
    chk("ret_need",   64'(jalr_need_rs1), 64'd0);
    tick();
    idle();
    #1;
    chk("ck_after_ret", 64'(pred_ras_ck), 64'h00);
    predict(32'h404, I_RET);
    #1;
    chk("ret_empty_taken", 64'(pred_taken),    64'd0);
    chk("ret_empty_need",  64'(jalr_need_rs1), 64'd1);
    tick();
    idle();
    #1;
    chk("ck_after_empty_pop", 64'(pred_ras_ck), 64'h00);
    predict(32'h500, I_JALR_ABS);
    #1;
    chk("jalr_abs_taken",  64'(pred_taken),  64'd1);
    chk("jalr_abs_target", 64'(pred_target), 64'h40);
    predict(32'h500, I_JALR_A0);
    #1;
    chk("jalr_a0_need",  64'(jalr_need_rs1), 64'd1);
    chk("jalr_a0_taken", 64'(pred_taken),    64'd0);
    idle();

    // Overflow: five calls into a four-deep stack.
    for (int i = 1; i <= 5; i++) begin
      predict(32'(i * 16), I_JAL_RA);
      tick();
      idle();
    end
    #1;
    chk("ck_full_wrapped", 64'(pred_ras_ck), 64'h0C);
    begin
      logic [31:0] exp_ret [4];
      exp_ret[0] = 32'h54;
      exp_ret[1] = 32'h44;
      exp_ret[2] = 32'h34;
      exp_ret[3] = 32'h24;
      for (int i = 0; i < 4; i++) begin
        predict(32'h600, I_RET);
        #1;
        chk($sformatf("ovf_ret%0d_target", i), 64'(pred_target), 64'(exp_ret[i]));
        tick();
        idle();
      end
    end
    #1;
    chk("ck_after_4_pops", 64'(pred_ras_ck), 64'h08);
    // Count is back to zero, so the fifth return has no prediction.
    predict(32'h600, I_RET);
    #1;
    chk("ovf_ret4_need",  64'(jalr_need_rs1), 64'd1);
    chk("ovf_ret4_taken", 64'(pred_taken),    64'd0);
    tick();
    idle();

    // Branch repair collides with a speculative branch shift.
    predict(32'h100, I_BEQ);
    update(32'h800, 1'b1, 1'b1, 1'b1, 8'h5A, 5'h0B);
    tick();
    idle();
    #1;
    chk("repair_bxx_ghr", 64'(pred_ghr),    64'hB5);
    chk("repair_bxx_ck",  64'(pred_ras_ck), 64'h0B);
    // Non-branch repair collides with a speculative push.
    predict(32'h700, I_JAL_RA);
    update(32'h700, 1'b0, 1'b1, 1'b1, 8'h33, 5'h12);
    tick();
    idle();
    #1;
    chk("repair_jmp_ghr", 64'(pred_ghr),    64'h33);
    chk("repair_jmp_ck",  64'(pred_ras_ck), 64'h12);

    // Same-index collision: PC 0x400 with GHR 0x33 and PC 0x4CC with GHR 0 both map to 0x133.
    predict(32'h400, I_BEQ);
    update(32'h4CC, 1'b1, 1'b1, 1'b0, 8'h00, 5'h00);
    #1;
    chk("coll_same_cycle", 64'(pred_taken), 64'd0);
    pred_valid = 1'b0;
    tick();
    idle();
    predict(32'h400, I_BEQ);
    #1;
    chk("coll_next_taken",  64'(pred_taken),  64'd1);
    chk("coll_next_target", 64'(pred_target), 64'h420);
    tick();
    idle();
    #1;
    chk("spec_shift_ghr", 64'(pred_ghr), 64'h67);

    // Reset in the same cycle as a repair, PHT update and a push.
    rst = 1'b1;
    predict(32'h900, I_JAL_RA);
    update(32'h100, 1'b1, 1'b1, 1'b1, 8'h00, 5'h07);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_mid_ghr", 64'(pred_ghr),    64'd0);
    chk("rst_mid_ck",  64'(pred_ras_ck), 64'd0);
    probe("rst_mid_pht", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
